// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 compression core: chains pre-padded 512-bit blocks, RPC rounds per clock.
// Define SHA224_MODE_EN to add the mode224_i port (SHA-224 IV, digest[31:0] forced to zero).
module sha256_stream_core #(
  parameter int unsigned  RPC = 1,
  parameter logic [255:0] IV  =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_data_i,
  input  logic         blk_first_i,
  input  logic         blk_last_i,
`ifdef SHA224_MODE_EN
  input  logic         mode224_i,
`endif
  output logic         busy_o,
  output logic [255:0] digest_o,
  output logic         digest_valid_o
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
    $error("sha256_stream_core: RPC must be 1, 2 or 4");
  end

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

  function automatic logic [31:0] ror(logic [31:0] x, int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Working vars packed a..h as [7]..[0]; window word W[round+i] sits at w[15-i].
  function automatic logic [255:0] run_rounds(logic [7:0][31:0] s_in, logic [5:0] r,
                                              logic [15:0][31:0] w);
    logic [7:0][31:0] s;
    logic [31:0]      t1;
    logic [31:0]      t2;
    s = s_in;
    for (int j = 0; j < RPC; j++) begin
      t1 = s[0] + bsig1(s[3]) + ((s[3] & s[2]) ^ (~s[3] & s[1])) + K[r + 6'(j)] + w[15-j];
      t2 = bsig0(s[7]) + ((s[7] & s[6]) ^ (s[7] & s[5]) ^ (s[6] & s[5]));
      s  = {t1 + t2, s[7:5], s[4] + t1, s[3:1]};
    end
    return s;
  endfunction

  // Later new words may consume earlier new words from the same cycle.
  function automatic logic [511:0] next_window(logic [15:0][31:0] w);
    logic [31:0]       x [16+RPC];
    logic [15:0][31:0] o;
    for (int i = 0; i < 16; i++) x[i] = w[15-i];
    for (int j = 0; j < RPC; j++) begin
      x[16+j] = ssig1(x[14+j]) + x[9+j] + ssig0(x[1+j]) + x[j];
    end
    for (int i = 0; i < 16; i++) o[15-i] = x[i+RPC];
    return o;
  endfunction

  state_e            st_q;
  logic [5:0]        rnd_q;
  logic [15:0][31:0] w_q;
  logic [7:0][31:0]  wv_q;
  logic [7:0][31:0]  base_q;
  logic [7:0][31:0]  chain_q;
  logic              last_q;
  logic              ready_q;
  logic              busy_q;
  logic [255:0]      digest_q;
  logic              dv_q;

  logic [7:0][31:0]  sum;
  logic [255:0]      first_iv;
  logic [255:0]      base_sel;

`ifdef SHA224_MODE_EN
  localparam logic [255:0] IV224 =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  logic mode_q;
  assign first_iv = mode224_i ? IV224 : IV;
`else
  assign first_iv = IV;
`endif

  assign base_sel = blk_first_i ? first_iv : chain_q;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++) sum[i] = base_q[i] + wv_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= StIdle;
      rnd_q    <= '0;
      w_q      <= '0;
      wv_q     <= '0;
      base_q   <= IV;
      chain_q  <= IV;
      last_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      digest_q <= '0;
      dv_q     <= 1'b0;
`ifdef SHA224_MODE_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      dv_q <= 1'b0;
      unique case (st_q)
        StIdle: begin
          if (blk_valid_i && ready_q) begin
            w_q     <= blk_data_i;
            wv_q    <= base_sel;
            base_q  <= base_sel;
            last_q  <= blk_last_i;
            rnd_q   <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            st_q    <= StRound;
`ifdef SHA224_MODE_EN
            if (blk_first_i) mode_q <= mode224_i;
`endif
          end
        end
        StRound: begin
          wv_q  <= run_rounds(wv_q, rnd_q, w_q);
          w_q   <= next_window(w_q);
          rnd_q <= rnd_q + 6'(RPC);
          if (rnd_q == 6'(64 - RPC)) st_q <= StFinal;
        end
        StFinal: begin
          chain_q <= sum;
          if (last_q) begin
`ifdef SHA224_MODE_EN
            digest_q <= mode_q ? {sum[7:1], 32'h0} : sum;
`else
            digest_q <= sum;
`endif
            dv_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          st_q    <= StIdle;
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign blk_ready_o    = ready_q;
  assign busy_o         = busy_q;
  assign digest_o       = digest_q;
  assign digest_valid_o = dv_q;

endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core: RPC=1/2/4 instances, known vectors plus random multi-block
// messages checked against a plain-arithmetic SHA-256 model.
module tb_sha256_stream_core;

  localparam logic [255:0] IV256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] TB1 = {
    256'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b,
    192'h696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071, 32'h80000000, 32'h0};
  localparam logic [511:0] TB2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         valid  [3];
  logic         ready  [3];
  logic [511:0] data   [3];
  logic         first  [3];
  logic         last   [3];
  logic         busy   [3];
  logic [255:0] digest [3];
  logic         dv     [3];
`ifdef SHA224_MODE_EN
  logic         mode   [3];
`endif

  logic [255:0] held    [3];  // digest each instance should currently be holding
  logic [255:0] chain_m [3];  // model chaining value per instance
  int           tests = 0;
  int           fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sha256_stream_core #(.RPC(1 << g)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .blk_valid_i   (valid[g]),
      .blk_ready_o   (ready[g]),
      .blk_data_i    (data[g]),
      .blk_first_i   (first[g]),
      .blk_last_i    (last[g]),
`ifdef SHA224_MODE_EN
      .mode224_i     (mode[g]),
`endif
      .busy_o        (busy[g]),
      .digest_o      (digest[g]),
      .digest_valid_o(dv[g])
    );
  end

  function automatic logic [31:0] rr(logic [31:0] x, int n);
    logic [63:0] xx;
    xx = {x, x} >> n;
    return xx[31:0];
  endfunction

  // Textbook SHA-256 compression of one block onto chaining value h.
  function automatic logic [255:0] compress(logic [255:0] h, logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  s [8];
    logic [31:0]  t1;
    logic [31:0]  t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) s[i] = h[255 - 32*i -: 32];
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    for (int t = 0; t < 64; t++) begin
      t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[t] + w[t];
      t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      for (int i = 7; i > 0; i--) s[i] = s[i-1];
      s[4] = s[4] + t1;
      s[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h[255 - 32*i -: 32] + s[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge; returns at the first negedge after the accepting edge.
  task automatic offer(input int g, input logic [511:0] d, input logic f, input logic l,
                       input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    data[g] = d; first[g] = f; last[g] = l; valid[g] = 1'b1;
    while (!ready[g] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("offer_ready", 256'(ready[g]), 256'd1);
    @(negedge clk);
    valid[g] = 1'b0;
  endtask

  task automatic wait_block(input int g, input logic l, input logic [255:0] exp,
                            input string tag);
    int lat = 0;
    int early = 0;
    chk({tag, "_busy"}, 256'(busy[g]), 256'd1);
    while (!ready[g] && lat < 200) begin
      if (dv[g]) early++;
      lat++;
      @(negedge clk);
    end
    chk({tag, "_ready_low"}, 256'(lat), 256'(64 / (1 << g) + 1));
    chk({tag, "_early_dv"}, 256'(early), 256'd0);
    chk({tag, "_dv"}, 256'(dv[g]), 256'(l));
    chk({tag, "_idle"}, 256'(busy[g]), 256'd0);
    chk({tag, "_digest"}, digest[g], exp);
    @(negedge clk);
    chk({tag, "_dv_width"}, 256'(dv[g]), 256'd0);
  endtask

  task automatic model_reset();
    for (int g = 0; g < 3; g++) begin
      held[g]    = '0;
      chain_m[g] = IV256;
    end
  endtask

  initial begin
    logic [511:0] blk;
    int           g;
    int           nb;
    int           n_dv;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0; data[i] = '0; first[i] = 1'b0; last[i] = 1'b0;
`ifdef SHA224_MODE_EN
      mode[i] = 1'b0;
`endif
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_ready%0d", i), 256'(ready[i]), 256'd1);
      chk($sformatf("reset_busy%0d", i), 256'(busy[i]), 256'd0);
      chk($sformatf("reset_digest%0d", i), digest[i], 256'd0);
      chk($sformatf("reset_dv%0d", i), 256'(dv[i]), 256'd0);
    end

    offer(0, ABC, 1'b1, 1'b1, 0);
    wait_block(0, 1'b1, ABC_DIG, "abc_rpc1");
    held[0] = ABC_DIG; chain_m[0] = ABC_DIG;

    offer(2, EMPTY, 1'b1, 1'b1, 0);
    wait_block(2, 1'b1, EMPTY_DIG, "empty_rpc4");
    held[2] = EMPTY_DIG; chain_m[2] = EMPTY_DIG;

    // Two-block message with blk_valid held high across the first block.
    offer(1, TB1, 1'b1, 1'b0, 0);
    valid[1] = 1'b1; data[1] = TB2; first[1] = 1'b0; last[1] = 1'b1;
    wait_block(1, 1'b0, held[1], "two_blk1");
    chk("two_held_accept_ready", 256'(ready[1]), 256'd0);
    chk("two_held_accept_busy", 256'(busy[1]), 256'd1);
    valid[1] = 1'b0;
    wait_block(1, 1'b1, TWO_DIG, "two_blk2");
    held[1] = TWO_DIG; chain_m[1] = TWO_DIG;

    for (int k = 0; k < 2; k++) begin
      offer(1, ABC, 1'b1, 1'b1, int'($urandom_range(0, 5)));
      wait_block(1, 1'b1, ABC_DIG, $sformatf("b2b_abc%0d", k));
    end
    held[1] = ABC_DIG; chain_m[1] = ABC_DIG;

    // Random messages; occasionally a continuation block without blk_first.
    for (int m = 0; m < 8; m++) begin
      g  = int'($urandom_range(0, 2));
      nb = int'($urandom_range(1, 3));
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom();
        chain_m[g] = compress((b == 0 && m % 4 != 3) ? IV256 : chain_m[g], blk);
        offer(g, blk, (b == 0 && m % 4 != 3), (b == nb - 1), int'($urandom_range(0, 3)));
        if (b == nb - 1) held[g] = chain_m[g];
        wait_block(g, (b == nb - 1), held[g], $sformatf("rand_m%0d_b%0d", m, b));
      end
    end

    // Reset during round 30: no digest, everything back to reset values.
    offer(0, ABC, 1'b1, 1'b1, 0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("abort_ready", 256'(ready[0]), 256'd1);
    chk("abort_busy", 256'(busy[0]), 256'd0);
    chk("abort_digest", digest[0], 256'd0);
    n_dv = 0;
    repeat (70) begin
      @(negedge clk);
      if (dv[0]) n_dv++;
    end
    chk("abort_no_dv", 256'(n_dv), 256'd0);
    offer(0, ABC, 1'b0, 1'b1, 1);
    wait_block(0, 1'b1, ABC_DIG, "abort_chain_iv");
    offer(0, ABC, 1'b1, 1'b1, 2);
    wait_block(0, 1'b1, ABC_DIG, "abort_then_abc");

`ifdef SHA224_MODE_EN
    mode[0] = 1'b1;
    offer(0, ABC, 1'b1, 1'b1, 1);
    mode[0] = 1'b0;
    wait_block(0, 1'b1,
      256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000,
      "sha224_abc");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
